// File: rtl/matrix_drain_pkg.sv
// Shared definitions for the matrix drain: element/index widths, FSM encoding, index helper.
// Optional build macro MATRIX_DRAIN_COLMAJOR_EN is consumed by matrix_drain.sv.
package matrix_drain_pkg;

    localparam int ELEM_W = 64;
    localparam int IDX_W  = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Largest index for a SIZE x SIZE matrix, truncated to the index port width.
    function automatic logic [IDX_W-1:0] idx_max(input int size);
        return IDX_W'(size - 1);
    endfunction

endpackage

// File: rtl/matrix_drain_if.sv
// Bus bundle between the multiplier result, the drain and an element-serial consumer.
// Modport master is the drain itself; modport slave is the environment around it.
interface matrix_drain_if
    import matrix_drain_pkg::*;
#(
    parameter int SIZE = 4
);

    logic [SIZE*SIZE*ELEM_W-1:0] mat_in;
    logic                        mat_valid;
    logic                        busy;
    logic [ELEM_W-1:0]           elem_data;
    logic [IDX_W-1:0]            elem_row;
    logic [IDX_W-1:0]            elem_col;
    logic                        elem_valid;
    logic                        elem_ready;
    logic                        elem_last;
    logic                        done;
    logic                        overrun;

    // Element stream: a beat transfers at a posedge where elem_valid & elem_ready are both high.
    // Once raised, elem_valid stays high with data/row/col/last frozen until that transfer happens.
    modport master (
        input  mat_in, mat_valid, elem_ready,
        output busy, elem_data, elem_row, elem_col, elem_valid, elem_last, done, overrun
    );

    modport slave (
        output mat_in, mat_valid, elem_ready,
        input  busy, elem_data, elem_row, elem_col, elem_valid, elem_last, done, overrun
    );

endinterface

// File: rtl/matrix_drain_idx_ctr.sv
// Two-level wrap counter: inner counts 0..SIZE-1, outer advances when inner wraps.
// wrap_o flags the increment that leaves the final (SIZE-1,SIZE-1) position.
module matrix_drain_idx_ctr
    import matrix_drain_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] inner_o,
    output logic [IDX_W-1:0] outer_o,
    output logic             last_o,
    output logic             wrap_o
);

    localparam logic [IDX_W-1:0] MAX = idx_max(SIZE);

    logic [IDX_W-1:0] inner_q, inner_d;
    logic [IDX_W-1:0] outer_q, outer_d;

    always_comb begin
        inner_d = inner_q;
        outer_d = outer_q;
        if (clear_i) begin
            inner_d = '0;
            outer_d = '0;
        end else if (inc_i) begin
            if (inner_q == MAX) begin
                inner_d = '0;
                outer_d = (outer_q == MAX) ? '0 : outer_q + IDX_W'(1);
            end else begin
                inner_d = inner_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end

    assign inner_o = inner_q;
    assign outer_o = outer_q;
    assign last_o  = (inner_q == MAX) && (outer_q == MAX);
    assign wrap_o  = inc_i && last_o;

endmodule

// File: rtl/matrix_drain.sv
// Captures a flat SIZE*SIZE matrix on a mat_valid rising edge and streams it one element per beat.
// Build macro MATRIX_DRAIN_COLMAJOR_EN selects column-major traversal (default row-major).
module matrix_drain
    import matrix_drain_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_drain_if.master       bus,
    output state_e               dbg_state_o
);

    localparam int BUS_W = SIZE * SIZE * ELEM_W;
    localparam int SEL_W = $clog2(BUS_W);

    state_e             state_q;
    logic               mv_q;
    logic               busy_q;
    logic               valid_q;
    logic               done_q;
    logic               overrun_q;
    logic [BUS_W-1:0]   buf_q;

    logic               start;
    logic               hs;
    logic               ctr_clear;
    logic               idx_last;
    logic               idx_wrap;
    logic [IDX_W-1:0]   inner_idx;
    logic [IDX_W-1:0]   outer_idx;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col;
    logic [SEL_W-1:0]   elem_lsb;

    assign start     = bus.mat_valid & ~mv_q;
    assign hs        = valid_q & bus.elem_ready;
    assign ctr_clear = (state_q == S_IDLE) & start;

    matrix_drain_idx_ctr #(.SIZE(SIZE)) u_idx_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (ctr_clear),
        .inc_i   (hs),
        .inner_o (inner_idx),
        .outer_o (outer_idx),
        .last_o  (idx_last),
        .wrap_o  (idx_wrap)
    );

`ifdef MATRIX_DRAIN_COLMAJOR_EN
    assign row = inner_idx;
    assign col = outer_idx;
`else
    assign row = outer_idx;
    assign col = inner_idx;
`endif

    // Element select from registered indices, so data only moves on an accepted beat.
    assign elem_lsb = SEL_W'((32'(row) * SIZE + 32'(col)) * ELEM_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mv_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            mv_q      <= bus.mat_valid;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        buf_q   <= bus.mat_in;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A new matrix arriving mid-stream (even on the final beat) is dropped.
                    overrun_q <= start;
                    if (idx_wrap) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.elem_valid = valid_q;
    assign bus.elem_data  = buf_q[elem_lsb +: ELEM_W];
    assign bus.elem_row   = row;
    assign bus.elem_col   = col;
    assign bus.elem_last  = valid_q & idx_last;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;
    assign dbg_state_o    = state_q;

endmodule
